// File: rtl/register_file_dump_pkg.sv
// Shared types and constants for the register file and its dump engine.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } dump_state_t;

  // Base bit offset of packed slice p when each slice is w bits wide.
  function automatic int unsigned slice_base(input int unsigned p, input int unsigned w);
    return p * w;
  endfunction

endpackage

// File: rtl/register_file_dump_if.sv
// Valid/ready dump stream between the register file and the debug consumer.
interface register_file_dump_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  logic                  dump_start;
  logic                  dump_ready;
  logic                  dump_valid;
  logic [ADDR_WIDTH-1:0] dump_index;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_busy;
  logic                  dump_done;

  modport master (
    input  dump_start, dump_ready,
    output dump_valid, dump_index, dump_data, dump_busy, dump_done
  );

  modport slave (
    output dump_start, dump_ready,
    input  dump_valid, dump_index, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/register_file_dump_dump_seq.sv
// Dump sequencer: walks every entry in index order and presents it on a
// registered valid/ready stream, pulsing dump_done after the last word.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  register_file_dump_if.master  dump,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

  dump_state_t           state;
  logic                  valid_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] index_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (dump.dump_start) begin
            index_q <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          data_q  <= rd_data;
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (valid_q && dump.dump_ready) begin
            valid_q <= 1'b0;
            // Terminate on the last index so the counter never wraps.
            if (index_q == LAST_INDEX) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              index_q <= index_q + 1'b1;
              state   <= LOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          index_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_addr         = index_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_index = index_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_done  = done_q;
  assign dump.dump_busy  = (state != IDLE);

endmodule

// File: rtl/register_file_dump.sv
// Register file with NUM_READ registered read ports, write bypass and a
// sequential dump engine. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_dump
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           read_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  input  logic                           write_en,
  input  logic [ADDR_WIDTH-1:0]          write_address,
  input  logic [DATA_WIDTH-1:0]          write_data,
  register_file_dump_if.master           dump
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  write_ok;
  logic [ADDR_WIDTH-1:0] dump_rd_addr;
  logic [DATA_WIDTH-1:0] dump_rd_data;

`ifdef REGFILE_ZERO_REG_EN
  assign write_ok = write_en && (write_address != '0);
`else
  assign write_ok = write_en;
`endif

  // Entry value as seen at this edge, including a same-cycle write.
  function automatic logic [DATA_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] addr);
    if (write_ok && (write_address == addr)) return write_data;
`ifdef REGFILE_ZERO_REG_EN
    if (addr == '0) return '0;
`endif
    return mem[addr];
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[write_address] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      read_data <= '0;
    end else if (read_en) begin
      for (int unsigned p = 0; p < NUM_READ; p++) begin
        read_data[slice_base(p, DATA_WIDTH) +: DATA_WIDTH] <=
          lookup(read_addr[slice_base(p, ADDR_WIDTH) +: ADDR_WIDTH]);
      end
    end
  end

  always_comb dump_rd_data = lookup(dump_rd_addr);

  regfile_dump_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dump_seq (
    .clock   (clock),
    .reset   (reset),
    .dump    (dump),
    .rd_addr (dump_rd_addr),
    .rd_data (dump_rd_data)
  );

endmodule

// File: tb/tb_register_file_dump.sv
// Directed self-checking bench for register_file_dump (default 32x32, 2 read ports).
module tb_register_file_dump;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_en;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic        write_en;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  register_file_dump_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dif ();

  register_file_dump #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_READ   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .read_en       (read_en),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .write_en      (write_en),
    .write_address (write_address),
    .write_data    (write_data),
    .dump          (dif.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    write_en      = 1'b1;
    write_address = addr;
    write_data    = data;
    tick();
    write_en      = 1'b0;
  endtask

  logic [31:0] zexp_fill;
  logic [31:0] zexp_byp;
  bit          found;
  bit          done_seen;

  initial begin
`ifdef REGFILE_ZERO_REG_EN
    zexp_fill = 32'h0;
    zexp_byp  = 32'h0;
`else
    zexp_fill = 32'hFFFF_FFFF;
    zexp_byp  = 32'hCAFE_0000;
`endif
    reset = 1'b0; read_en = 1'b0; read_addr = '0;
    write_en = 1'b0; write_address = '0; write_data = '0;
    dif.dump_start = 1'b0; dif.dump_ready = 1'b0;
    tick(); tick();

    // Reset state
    reset = 1'b1; read_en = 1'b1; read_addr = {5'd5, 5'd3};
    tick();
    check("rst_rd0", read_data[31:0], 32'h0);
    check("rst_rd1", read_data[63:32], 32'h0);
    check("rst_valid", 32'(dif.dump_valid), 32'h0);
    check("rst_busy", 32'(dif.dump_busy), 32'h0);
    check("rst_done", 32'(dif.dump_done), 32'h0);
    check("rst_index", 32'(dif.dump_index), 32'h0);
    check("rst_data", dif.dump_data, 32'h0);
    read_en = 1'b0;

    // Write then read
    wr(5'd7, 32'hDEAD_BEEF);
    read_en = 1'b1; read_addr = {5'd3, 5'd7};
    tick();
    check("wr_rd0", read_data[31:0], 32'hDEAD_BEEF);
    check("wr_rd1", read_data[63:32], 32'h0);
    read_en = 1'b0; read_addr = {5'd0, 5'd0};
    tick();
    check("hold_rd0", read_data[31:0], 32'hDEAD_BEEF);

    // Same-cycle bypass
    read_en = 1'b1; read_addr = {5'd9, 5'd7};
    wr(5'd9, 32'h1234_5678);
    check("byp_rd1", read_data[63:32], 32'h1234_5678);
    check("byp_rd0", read_data[31:0], 32'hDEAD_BEEF);
    read_en = 1'b0;

    // Preload entry[i] = i*4
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 4));

    // Full dump with ready held high; observation c is cycle c after dump_start
    dif.dump_ready = 1'b1; dif.dump_start = 1'b1;
    tick();
    dif.dump_start = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      bit ev;
      ev = (c >= 2) && (c <= 64) && (c % 2 == 0);
      check("full_valid", 32'(dif.dump_valid), 32'(ev));
      check("full_busy", 32'(dif.dump_busy), 32'((c >= 1) && (c <= 65)));
      check("full_done", 32'(dif.dump_done), 32'(c == 65));
      if (ev) begin
        check("full_index", 32'(dif.dump_index), 32'((c - 2) / 2));
        check("full_data", dif.dump_data, 32'(((c - 2) / 2) * 4));
      end
      tick();
    end

    // Backpressure at index 3, writes during the dump, then reset mid-dump
    dif.dump_start = 1'b1;
    tick();
    dif.dump_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (dif.dump_valid && dif.dump_index == 5'd3) found = 1'b1;
      else tick();
    end
    check("bp_reach", 32'(found), 32'h1);
    dif.dump_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      write_en      = (n < 2);
      write_address = (n == 0) ? 5'd3 : 5'd5;
      write_data    = (n == 0) ? 32'h0000_AAAA : 32'h0000_5555;
      tick();
      write_en = 1'b0;
      check("bp_valid", 32'(dif.dump_valid), 32'h1);
      check("bp_index", 32'(dif.dump_index), 32'd3);
      check("bp_data", dif.dump_data, 32'd12);
    end
    dif.dump_ready = 1'b1;
    tick();
    check("bp_hs_valid", 32'(dif.dump_valid), 32'h0);
    tick();
    check("bp_idx4", 32'(dif.dump_index), 32'd4);
    check("bp_data4", dif.dump_data, 32'd16);
    tick(); tick();
    check("bp_idx5", 32'(dif.dump_index), 32'd5);
    check("bp_data5", dif.dump_data, 32'h0000_5555);
    reset = 1'b0;
    tick();
    check("mid_rst_busy", 32'(dif.dump_busy), 32'h0);
    check("mid_rst_valid", 32'(dif.dump_valid), 32'h0);
    check("mid_rst_index", 32'(dif.dump_index), 32'h0);
    check("mid_rst_data", dif.dump_data, 32'h0);
    reset = 1'b1;
    done_seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (dif.dump_done) done_seen = 1'b1;
      tick();
    end
    check("mid_rst_no_done", 32'(done_seen), 32'h0);
    check("mid_rst_busy2", 32'(dif.dump_busy), 32'h0);
    read_en = 1'b1; read_addr = {5'd5, 5'd7};
    tick();
    check("mid_rst_clr7", read_data[31:0], 32'h0);
    check("mid_rst_clr5", read_data[63:32], 32'h0);
    read_en = 1'b0;

    // Entry 0 behaviour (hardwired only with REGFILE_ZERO_REG_EN)
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd1, 32'h0000_0011);
    read_en = 1'b1; read_addr = {5'd1, 5'd0};
    tick();
    check("z_rd0", read_data[31:0], zexp_fill);
    check("z_rd1", read_data[63:32], 32'h0000_0011);
    wr(5'd0, 32'hCAFE_0000);
    check("z_byp0", read_data[31:0], zexp_byp);
    read_en = 1'b0;
    dif.dump_ready = 1'b1; dif.dump_start = 1'b1;
    tick();
    dif.dump_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (dif.dump_valid) found = 1'b1;
      else tick();
    end
    check("z_dump_valid", 32'(found), 32'h1);
    check("z_dump_index", 32'(dif.dump_index), 32'h0);
    check("z_dump_data", dif.dump_data, zexp_byp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
